// File: rtl/tl45_pipe_ctrl.sv
// tl45 pipeline sequencing controller: scoreboarded issue gating, stall/flush
// generation, branch redirect sequencing and halt/drain/resume flow.
module tl45_pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_dec_opcode,
    input  logic [3:0]  i_dec_dr,
    input  logic [3:0]  i_dec_sr1,
    input  logic [3:0]  i_dec_sr2,
    input  logic        i_ex_ready,
    output logic        o_issue,
    output logic        o_pipe_stall,
    output logic        o_pipe_flush,
    input  logic        i_wb_valid,
    input  logic [3:0]  i_wb_dr,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    input  logic        i_resume,
    input  logic [31:0] i_resume_pc,
    output logic        o_fetch_pc_load,
    output logic [31:0] o_fetch_pc,
    output logic        o_halted,
    output logic [15:0] o_busy_mask
);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN, S_HALTED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]       FC_INIT = 3'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        fetch_load_q, fetch_load_d;

    logic [15:0][CNT_W-1:0] cnt_w;

    logic valid, use_sr1, use_sr2, wr_op, writer, hazard, all_idle;
    logic issue, stall, flush, halted;

    // Operand usage and destination write decode
    always_comb begin
        use_sr1 = 1'b0;
        use_sr2 = 1'b0;
        wr_op   = 1'b0;
        case (i_dec_opcode)
            4'h0, 4'h1:       begin use_sr1 = 1'b1; use_sr2 = 1'b1; wr_op = 1'b1; end
            4'h4, 4'h8:       begin use_sr1 = 1'b1; use_sr2 = 1'b1; end
            4'h2, 4'h3, 4'h6: begin use_sr1 = 1'b1; wr_op = 1'b1; end
            4'h9:             wr_op = 1'b1;
            default:          ;
        endcase
    end

    assign valid  = (i_dec_opcode != 4'hF);
    assign writer = wr_op && (i_dec_dr != 4'd0);
    assign hazard = (use_sr1 && (i_dec_sr1 != 4'd0) && (cnt_w[i_dec_sr1] != '0))
                 || (use_sr2 && (i_dec_sr2 != 4'd0) && (cnt_w[i_dec_sr2] != '0))
                 || (writer && (cnt_w[i_dec_dr] == CNT_MAX));
    assign all_idle = (o_busy_mask == 16'd0);

    // Per-register pending-write counters; register 0 is hardwired idle
    for (genvar gi = 0; gi < 16; gi++) begin : g_cnt
        if (gi == 0) begin : g_zero
            assign cnt_w[gi] = '0;
        end else begin : g_reg
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic inc, dec;
            assign inc = issue && writer && (i_dec_dr == 4'(gi));
            assign dec = i_wb_valid && (i_wb_dr == 4'(gi));
            always_comb begin
                cnt_d = cnt_q;
                if (inc && !dec)
                    cnt_d = cnt_q + CNT_W'(1);
                else if (dec && !inc && (cnt_q != '0))
                    cnt_d = cnt_q - CNT_W'(1);
            end
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) cnt_q <= '0;
                else         cnt_q <= cnt_d;
            end
            assign cnt_w[gi] = cnt_q;
        end
        assign o_busy_mask[gi] = (cnt_w[gi] != '0);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_RUN;
            flush_cnt_q  <= 3'd0;
            fetch_pc_q   <= 32'd0;
            fetch_load_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            fetch_pc_q   <= fetch_pc_d;
            fetch_load_q <= fetch_load_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        fetch_pc_d   = fetch_pc_q;
        fetch_load_d = 1'b0;
        case (state_q)
            S_RUN: begin
                if (i_halt) begin
                    state_d = S_DRAIN;
                end else if (i_redirect_valid) begin
                    state_d      = S_FLUSH;
                    flush_cnt_d  = FC_INIT;
                    fetch_pc_d   = i_redirect_pc;
                    fetch_load_d = 1'b1;
                end
            end
            S_FLUSH: begin
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (i_halt)
                    state_d = S_DRAIN;
                else if (flush_cnt_q <= 3'd1)
                    state_d = S_RUN;
            end
            S_DRAIN: begin
                if (all_idle) state_d = S_HALTED;
            end
            S_HALTED: begin
                if (i_resume) begin
                    state_d      = S_FLUSH;
                    flush_cnt_d  = FC_INIT;
                    fetch_pc_d   = i_resume_pc;
                    fetch_load_d = 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        issue  = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        halted = 1'b0;
        case (state_q)
            S_RUN: begin
                issue = valid && !hazard && i_ex_ready && !i_redirect_valid && !i_halt;
                stall = valid && !issue;
            end
            S_FLUSH, S_DRAIN: flush = 1'b1;
            S_HALTED: begin
                halted = 1'b1;
                flush  = 1'b1;
                stall  = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_issue         = issue;
    assign o_pipe_stall    = stall;
    assign o_pipe_flush    = flush;
    assign o_halted        = halted;
    assign o_fetch_pc      = fetch_pc_q;
    assign o_fetch_pc_load = fetch_load_q;

endmodule

// File: tb/tb_tl45_pipe_ctrl.sv
// Bench for tl45_pipe_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_tl45_pipe_ctrl;

    localparam int FC  = 2;
    localparam int MAX = 3;
    localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2, M_HALTED = 3;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [3:0]  i_dec_opcode, i_dec_dr, i_dec_sr1, i_dec_sr2;
    logic        i_ex_ready;
    logic        o_issue, o_pipe_stall, o_pipe_flush;
    logic        i_wb_valid;
    logic [3:0]  i_wb_dr;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        i_halt, i_resume;
    logic [31:0] i_resume_pc;
    logic        o_fetch_pc_load;
    logic [31:0] o_fetch_pc;
    logic        o_halted;
    logic [15:0] o_busy_mask;

    int n_checks = 0;
    int n_errors = 0;
    bit run_chk  = 1'b0;

    // Behavioural model state
    int          m_cnt [16];
    int          m_mode;
    int          m_flush_left;
    logic [31:0] m_pc;
    bit          m_load;

    tl45_pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(2)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_dec_opcode(i_dec_opcode), .i_dec_dr(i_dec_dr),
        .i_dec_sr1(i_dec_sr1), .i_dec_sr2(i_dec_sr2),
        .i_ex_ready(i_ex_ready),
        .o_issue(o_issue), .o_pipe_stall(o_pipe_stall), .o_pipe_flush(o_pipe_flush),
        .i_wb_valid(i_wb_valid), .i_wb_dr(i_wb_dr),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
        .i_halt(i_halt), .i_resume(i_resume), .i_resume_pc(i_resume_pc),
        .o_fetch_pc_load(o_fetch_pc_load), .o_fetch_pc(o_fetch_pc),
        .o_halted(o_halted), .o_busy_mask(o_busy_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_valid();
        return i_dec_opcode != 4'hF;
    endfunction

    function automatic bit m_writer();
        return (i_dec_opcode inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h9}) && (i_dec_dr != 4'd0);
    endfunction

    function automatic bit m_hazard();
        bit u1, u2;
        u1 = i_dec_opcode inside {4'h0, 4'h1, 4'h4, 4'h8, 4'h2, 4'h3, 4'h6};
        u2 = i_dec_opcode inside {4'h0, 4'h1, 4'h4, 4'h8};
        return (u1 && i_dec_sr1 != 0 && m_cnt[i_dec_sr1] > 0)
            || (u2 && i_dec_sr2 != 0 && m_cnt[i_dec_sr2] > 0)
            || (m_writer() && m_cnt[i_dec_dr] == MAX);
    endfunction

    function automatic bit e_issue();
        return m_mode == M_RUN && m_valid() && !m_hazard() && i_ex_ready
            && !i_redirect_valid && !i_halt;
    endfunction

    function automatic bit e_stall();
        if (m_mode == M_HALTED) return 1'b1;
        if (m_mode == M_RUN)    return m_valid() && !e_issue();
        return 1'b0;
    endfunction

    function automatic logic [15:0] e_busy();
        logic [15:0] b;
        for (int r = 0; r < 16; r++) b[r] = (m_cnt[r] > 0);
        return b;
    endfunction

    function automatic bit m_all_idle();
        for (int r = 0; r < 16; r++) if (m_cnt[r] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Model advance at each clock edge
    always @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            for (int r = 0; r < 16; r++) m_cnt[r] <= 0;
            m_mode <= M_RUN; m_flush_left <= 0; m_pc <= 32'd0; m_load <= 1'b0;
        end else begin
            bit iss;
            iss = e_issue();
            for (int r = 1; r < 16; r++) begin
                bit inc, dec;
                inc = iss && m_writer() && (i_dec_dr == r);
                dec = i_wb_valid && (i_wb_dr == r);
                if (inc && !dec)                    m_cnt[r] <= m_cnt[r] + 1;
                else if (dec && !inc && m_cnt[r] > 0) m_cnt[r] <= m_cnt[r] - 1;
            end
            m_load <= 1'b0;
            case (m_mode)
                M_RUN:
                    if (i_halt) m_mode <= M_DRAIN;
                    else if (i_redirect_valid) begin
                        m_mode <= M_FLUSH; m_flush_left <= FC; m_pc <= i_redirect_pc; m_load <= 1'b1;
                    end
                M_FLUSH: begin
                    m_flush_left <= m_flush_left - 1;
                    if (i_halt) m_mode <= M_DRAIN;
                    else if (m_flush_left - 1 == 0) m_mode <= M_RUN;
                end
                M_DRAIN:
                    if (m_all_idle()) m_mode <= M_HALTED;
                default:
                    if (i_resume) begin
                        m_mode <= M_FLUSH; m_flush_left <= FC; m_pc <= i_resume_pc; m_load <= 1'b1;
                    end
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!i_reset && run_chk) begin
            chk("issue", {31'd0, o_issue}, {31'd0, e_issue()});
            if (m_mode != M_DRAIN) chk("stall", {31'd0, o_pipe_stall}, {31'd0, e_stall()});
            chk("flush", {31'd0, o_pipe_flush}, {31'd0, (m_mode != M_RUN)});
            chk("halted", {31'd0, o_halted}, {31'd0, (m_mode == M_HALTED)});
            chk("pc_load", {31'd0, o_fetch_pc_load}, {31'd0, m_load});
            chk("fetch_pc", o_fetch_pc, m_pc);
            chk("busy_mask", {16'd0, o_busy_mask}, {16'd0, e_busy()});
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_dec(input logic [3:0] op, input logic [3:0] dr, input logic [3:0] s1, input logic [3:0] s2);
        i_dec_opcode = op; i_dec_dr = dr; i_dec_sr1 = s1; i_dec_sr2 = s2;
    endtask

    task automatic wb(input logic v, input logic [3:0] r);
        i_wb_valid = v; i_wb_dr = r;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        i_reset = 1'b1;
        set_dec(4'hF, 0, 0, 0);
        i_ex_ready = 1'b1; wb(0, 0);
        i_redirect_valid = 0; i_redirect_pc = 0;
        i_halt = 0; i_resume = 0; i_resume_pc = 0;
        repeat (2) @(posedge clk);
        #1 i_reset = 1'b0;
        run_chk = 1'b1;

        // Reset state
        at_neg();
        chk("rst_issue", {31'd0, o_issue}, 0);
        chk("rst_stall", {31'd0, o_pipe_stall}, 0);
        chk("rst_flush", {31'd0, o_pipe_flush}, 0);
        chk("rst_halted", {31'd0, o_halted}, 0);
        chk("rst_busy", {16'd0, o_busy_mask}, 0);
        chk("rst_pc", o_fetch_pc, 0);
        $display("reset: outputs idle");

        // Independent stream
        tick(); set_dec(4'h0, 4'd1, 4'd2, 4'd3);
        at_neg(); chk("indep_add_issue", {31'd0, o_issue}, 1);
        tick(); set_dec(4'h2, 4'd4, 4'd5, 4'd0);
        at_neg(); chk("indep_addi_issue", {31'd0, o_issue}, 1);
        tick(); set_dec(4'hF, 0, 0, 0);
        at_neg(); chk("indep_busy", {16'd0, o_busy_mask}, 32'h12);
        $display("independent stream: busy_mask=0x%04h", o_busy_mask);

        // RAW stall on r1, writeback at cycle N, issue at N+1
        tick(); set_dec(4'h3, 4'd6, 4'd1, 4'd0);
        at_neg(); chk("raw_stall0", {31'd0, o_pipe_stall}, 1);
        tick();
        at_neg(); chk("raw_stall1", {31'd0, o_issue}, 0);
        tick(); wb(1, 4'd1);
        at_neg(); chk("raw_stall_wb", {31'd0, o_pipe_stall}, 1);
        tick(); wb(0, 0);
        at_neg(); chk("raw_issue_n1", {31'd0, o_issue}, 1);
        $display("RAW: LW issued one cycle after writeback");
        tick(); set_dec(4'hF, 0, 0, 0); wb(1, 4'd4);
        tick(); wb(1, 4'd6);
        tick(); wb(0, 0);

        // Saturation of r7 and concurrent issue+writeback
        set_dec(4'h2, 4'd7, 4'd0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            at_neg(); chk("sat_issue", {31'd0, o_issue}, 1);
            tick();
        end
        at_neg(); chk("sat_stall", {31'd0, o_pipe_stall}, 1);
        tick(); wb(1, 4'd7);
        at_neg(); chk("sat_stall_wb", {31'd0, o_issue}, 0);
        tick();
        at_neg(); chk("concurrent_issue", {31'd0, o_issue}, 1);
        tick(); wb(0, 0);
        at_neg(); chk("refill_issue", {31'd0, o_issue}, 1);
        tick();
        at_neg(); chk("resat_stall", {31'd0, o_pipe_stall}, 1);
        $display("saturation: r7 saturated, concurrent update held count");
        tick(); set_dec(4'hF, 0, 0, 0); wb(1, 4'd7);
        tick(); tick(); wb(0, 0);
        at_neg(); chk("sat_busy_1left", {31'd0, o_busy_mask[7]}, 1);
        tick(); wb(1, 4'd7);
        tick(); wb(0, 0);
        at_neg(); chk("sat_busy_clear", {16'd0, o_busy_mask}, 0);

        // Redirect to 0x40
        tick(); set_dec(4'h0, 4'd8, 4'd9, 4'd10); i_redirect_valid = 1; i_redirect_pc = 32'h40;
        at_neg(); chk("redir_T_issue", {31'd0, o_issue}, 0);
        tick(); i_redirect_valid = 0; i_redirect_pc = 32'h99;
        at_neg();
        chk("redir_T1_flush", {31'd0, o_pipe_flush}, 1);
        chk("redir_T1_load", {31'd0, o_fetch_pc_load}, 1);
        chk("redir_T1_pc", o_fetch_pc, 32'h40);
        chk("redir_T1_issue", {31'd0, o_issue}, 0);
        tick();
        at_neg();
        chk("redir_T2_flush", {31'd0, o_pipe_flush}, 1);
        chk("redir_T2_load", {31'd0, o_fetch_pc_load}, 0);
        chk("redir_T2_issue", {31'd0, o_issue}, 0);
        tick();
        at_neg();
        chk("redir_T3_flush", {31'd0, o_pipe_flush}, 0);
        chk("redir_T3_issue", {31'd0, o_issue}, 1);
        $display("redirect: fetch_pc=0x%0h, issue resumed", o_fetch_pc);
        tick(); set_dec(4'hF, 0, 0, 0); wb(1, 4'd8);

        // Halt with simultaneous redirect while r3 pending
        tick(); wb(0, 0); set_dec(4'h0, 4'd3, 4'd0, 4'd0);
        tick(); set_dec(4'hF, 0, 0, 0); i_halt = 1; i_redirect_valid = 1; i_redirect_pc = 32'h80;
        tick(); i_halt = 0; i_redirect_valid = 0;
        at_neg();
        chk("drain_flush", {31'd0, o_pipe_flush}, 1);
        chk("drain_no_load", {31'd0, o_fetch_pc_load}, 0);
        chk("drain_halted", {31'd0, o_halted}, 0);
        tick(); wb(1, 4'd3);
        at_neg(); chk("drain_wait", {31'd0, o_halted}, 0);
        tick(); wb(0, 0);
        tick();
        at_neg();
        chk("halted", {31'd0, o_halted}, 1);
        chk("halted_stall", {31'd0, o_pipe_stall}, 1);
        chk("halt_pc_kept", o_fetch_pc, 32'h40);
        $display("halt: drained and halted");
        tick(); i_resume = 1; i_resume_pc = 32'h100;
        tick(); i_resume = 0;
        at_neg();
        chk("resume_load", {31'd0, o_fetch_pc_load}, 1);
        chk("resume_pc", o_fetch_pc, 32'h100);
        chk("resume_halted", {31'd0, o_halted}, 0);
        tick(); tick();
        at_neg(); chk("resume_run", {31'd0, o_pipe_flush}, 0);
        $display("resume: fetch_pc=0x%0h, running", o_fetch_pc);

        // Asynchronous reset mid-DRAIN
        tick(); set_dec(4'h0, 4'd5, 4'd0, 4'd0);
        tick(); set_dec(4'hF, 0, 0, 0); i_halt = 1;
        tick(); i_halt = 0;
        #2 i_reset = 1'b1;
        #1;
        chk("arst_flush", {31'd0, o_pipe_flush}, 0);
        chk("arst_busy", {16'd0, o_busy_mask}, 0);
        chk("arst_pc", o_fetch_pc, 0);
        chk("arst_halted", {31'd0, o_halted}, 0);
        chk("arst_load", {31'd0, o_fetch_pc_load}, 0);
        $display("async reset mid-drain: outputs cleared");
        tick(); i_reset = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(0, 5) == 0) set_dec(4'hF, 0, 0, 0);
            else set_dec(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            i_ex_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 4) begin
                logic [3:0] r;
                r = 4'($urandom_range(0, 15));
                for (int t = 0; t < 16 && $urandom_range(0, 4) != 0; t++) begin
                    if (m_cnt[r] > 0) break;
                    r = 4'($urandom_range(1, 15));
                end
                wb(1, r);
            end else wb(0, 0);
            i_redirect_valid = ($urandom_range(0, 14) == 0);
            i_redirect_pc    = $urandom;
            i_halt           = ($urandom_range(0, 59) == 0);
            i_resume         = ($urandom_range(0, 7) == 0);
            i_resume_pc      = $urandom;
        end
        tick();
        $display("random phase: 4000 cycles compared");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
